// File: rtl/phy_lane_scheduler_if.sv
// Lane-source / serializer-side signal bundle for phy_lane_scheduler.
// master = lane sources plus downstream ready; slave = the scheduler itself.
interface phy_lane_scheduler_if;
   logic [7:0] In0, In1, In2, In3;
   logic       valid0, valid1, valid2, valid3;
   logic       out_ready;
   logic       full0, full1, full2, full3;
   logic       overflow;
   logic [7:0] data_out;
   logic       k_out;
   logic       valid_out;
   logic [1:0] lane_id;
   logic       active;

   modport master (
      output In0, In1, In2, In3, valid0, valid1, valid2, valid3, out_ready,
      input  full0, full1, full2, full3, overflow, data_out, k_out, valid_out,
             lane_id, active
   );

   modport slave (
      input  In0, In1, In2, In3, valid0, valid1, valid2, valid3, out_ready,
      output full0, full1, full2, full3, overflow, data_out, k_out, valid_out,
             lane_id, active
   );
endinterface

// File: rtl/phy_lane_scheduler.sv
// Four-lane byte scheduler into the PHY serializer: per-lane FIFOs, COM training
// burst after reset, then round-robin grant with IDLE fill on empty slots.
module phy_lane_scheduler #(
   parameter int         FIFO_DEPTH = 4,
   parameter int         COM_COUNT  = 4,
   parameter logic [7:0] COM_SYM    = 8'hBC,
   parameter logic [7:0] IDLE_SYM   = 8'h7C
) (
   input  logic                 clk,
   input  logic                 reset,
   phy_lane_scheduler_if.slave  bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(COM_COUNT + 1);

   typedef enum logic {TRAIN, RUN} state_t;

   logic [7:0]    lane_data [4];
   logic [3:0]    lane_valid;

   logic [7:0]    mem_q [4][FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q [4];
   logic [AW-1:0] rd_ptr_q [4];
   logic [AW:0]   cnt_q [4];
   logic [AW:0]   cnt_d [4];
   logic [3:0]    full, empty, push, pop;

   state_t        state_q, state_d;
   logic [CW-1:0] com_cnt_q, com_cnt_d;
   logic [1:0]    last_grant_q, last_grant_d;
   logic [7:0]    data_q, data_d;
   logic          k_q, k_d;
   logic          vout_q, vout_d;
   logic [1:0]    lane_q, lane_d;
   logic          active_q, active_d;
   logic          overflow_q, overflow_d;

   logic          grant_found;
   logic [1:0]    grant_lane;

   assign lane_data[0] = bus.In0;
   assign lane_data[1] = bus.In1;
   assign lane_data[2] = bus.In2;
   assign lane_data[3] = bus.In3;
   assign lane_valid   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

   // Status comes from start-of-cycle counts, so a same-edge push is invisible
   // to arbitration and a same-edge pop never makes room for a write.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         full[i]  = (cnt_q[i] == (AW+1)'(FIFO_DEPTH));
         empty[i] = (cnt_q[i] == '0);
         push[i]  = lane_valid[i] & ~full[i];
      end
   end

   assign overflow_d = overflow_q | (|(lane_valid & full));

   always_comb begin
      logic [1:0] cand;
      grant_found = 1'b0;
      grant_lane  = 2'd0;
      cand        = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant_q + 2'(k);
         if (!grant_found && !empty[cand]) begin
            grant_found = 1'b1;
            grant_lane  = cand;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      com_cnt_d    = com_cnt_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      k_d          = k_q;
      vout_d       = vout_q;
      lane_d       = lane_q;
      active_d     = active_q;
      pop          = 4'b0000;

      case (state_q)
         TRAIN: begin
            if (bus.out_ready) begin
               data_d    = COM_SYM;
               k_d       = 1'b1;
               vout_d    = 1'b0;
               lane_d    = 2'd0;
               com_cnt_d = com_cnt_q + CW'(1);
               if (com_cnt_q == CW'(COM_COUNT - 1)) state_d = RUN;
            end
         end
         RUN: begin
            if (bus.out_ready) begin
               active_d = 1'b1;
               if (grant_found) begin
                  pop[grant_lane] = 1'b1;
                  data_d       = mem_q[grant_lane][rd_ptr_q[grant_lane]];
                  k_d          = 1'b0;
                  vout_d       = 1'b1;
                  lane_d       = grant_lane;
                  last_grant_d = grant_lane;
               end else begin
                  data_d = IDLE_SYM;
                  k_d    = 1'b1;
                  vout_d = 1'b0;
                  lane_d = 2'd0;
               end
            end
         end
         default: state_d = TRAIN;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         case ({push[i], pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + (AW+1)'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - (AW+1)'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= TRAIN;
         com_cnt_q    <= '0;
         last_grant_q <= 2'd3;
         data_q       <= 8'h00;
         k_q          <= 1'b0;
         vout_q       <= 1'b0;
         lane_q       <= 2'd0;
         active_q     <= 1'b0;
         overflow_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         state_q      <= state_d;
         com_cnt_q    <= com_cnt_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         k_q          <= k_d;
         vout_q       <= vout_d;
         lane_q       <= lane_d;
         active_q     <= active_d;
         overflow_q   <= overflow_d;
         for (int i = 0; i < 4; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // NOTE: storage is left unreset; clearing the pointers and counts already empties every FIFO.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= lane_data[i];
      end
   end

   assign bus.data_out  = data_q;
   assign bus.k_out     = k_q;
   assign bus.valid_out = vout_q;
   assign bus.lane_id   = lane_q;
   assign bus.active    = active_q;
   assign bus.overflow  = overflow_q;
   assign bus.full0     = full[0];
   assign bus.full1     = full[1];
   assign bus.full2     = full[2];
   assign bus.full3     = full[3];

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Scoreboard bench for phy_lane_scheduler: a queue-based lane model predicts each
// output word, a negedge monitor pops and compares, directed cases then random traffic.
module tb_phy_lane_scheduler;

   localparam int         FIFO_DEPTH = 4;
   localparam int         COM_COUNT  = 4;
   localparam logic [7:0] COM_SYM    = 8'hBC;
   localparam logic [7:0] IDLE_SYM   = 8'h7C;

   typedef struct packed {
      logic [7:0] data;
      logic       k;
      logic       v;
      logic [1:0] lane;
      logic       act;
   } out_t;

   logic clk;
   logic reset;
   phy_lane_scheduler_if bus ();

   phy_lane_scheduler #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .COM_COUNT  (COM_COUNT),
      .COM_SYM    (COM_SYM),
      .IDLE_SYM   (IDLE_SYM)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one byte queue per lane plus the scheduler's visible state.
   logic [7:0] q_m [4][$];
   out_t       exp_q [$];
   out_t       last_m;
   logic       ovf_m;
   int         com_m;
   bit         run_m;
   int         lg_m;
   bit         act_m;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) q_m[i].delete();
      exp_q.delete();
      ovf_m = 1'b0;
      com_m = 0;
      run_m = 1'b0;
      lg_m  = 3;
      act_m = 1'b0;
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic rdy);
      bus.valid0 = v[0]; bus.valid1 = v[1]; bus.valid2 = v[2]; bus.valid3 = v[3];
      bus.In0 = d[7:0]; bus.In1 = d[15:8]; bus.In2 = d[23:16]; bus.In3 = d[31:24];
      bus.out_ready = rdy;
   endtask

   // One clock: apply inputs, let the edge happen, then advance the model with the same inputs.
   task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rdy);
      bit   full_s [4];
      bit   ne_s   [4];
      bit   found;
      out_t o;
      drive(v, d, rdy);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         full_s[i] = (q_m[i].size() == FIFO_DEPTH);
         ne_s[i]   = (q_m[i].size() != 0);
      end
      if (rdy) begin
         o = '0;
         if (!run_m) begin
            o.data = COM_SYM;
            o.k    = 1'b1;
            o.act  = act_m;
            com_m++;
            if (com_m == COM_COUNT) run_m = 1'b1;
         end else begin
            act_m = 1'b1;
            o.act = 1'b1;
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               int l;
               l = (lg_m + k) % 4;
               if (!found && ne_s[l]) begin
                  found  = 1'b1;
                  o.data = q_m[l].pop_front();
                  o.v    = 1'b1;
                  o.lane = 2'(l);
                  lg_m   = l;
               end
            end
            if (!found) begin
               o.data = IDLE_SYM;
               o.k    = 1'b1;
            end
         end
         exp_q.push_back(o);
      end
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            if (full_s[i]) ovf_m = 1'b1;
            else           q_m[i].push_back(d[8*i +: 8]);
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 32'h0, 1'b1);
   endtask

   // Reset is raised between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_data_out",  32'(bus.data_out),  32'h0);
      check("rst_k_out",     32'(bus.k_out),     32'h0);
      check("rst_valid_out", 32'(bus.valid_out), 32'h0);
      check("rst_lane_id",   32'(bus.lane_id),   32'h0);
      check("rst_active",    32'(bus.active),    32'h0);
      check("rst_full",      32'({bus.full3, bus.full2, bus.full1, bus.full0}), 32'h0);
      check("rst_overflow",  32'(bus.overflow),  32'h0);
      model_reset();
      drive(4'b0000, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compare each newly registered word, or the held word when nothing was issued.
   always @(negedge clk) begin
      out_t e;
      if (reset) begin
         last_m = '0;
      end else begin
         if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            last_m = e;
         end else begin
            e = last_m;
         end
         check("data_out",  32'(bus.data_out),  32'(e.data));
         check("k_out",     32'(bus.k_out),     32'(e.k));
         check("valid_out", 32'(bus.valid_out), 32'(e.v));
         check("lane_id",   32'(bus.lane_id),   32'(e.lane));
         check("active",    32'(bus.active),    32'(e.act));
         check("full", 32'({bus.full3, bus.full2, bus.full1, bus.full0}),
               32'({q_m[3].size() == FIFO_DEPTH, q_m[2].size() == FIFO_DEPTH,
                    q_m[1].size() == FIFO_DEPTH, q_m[0].size() == FIFO_DEPTH}));
         check("overflow",  32'(bus.overflow),  32'(ovf_m));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset  = 1'b0;
      last_m = '0;
      model_reset();
      drive(4'b0000, 32'h0, 1'b0);
      #2;
      do_reset();

      // COM burst, then IDLE fill
      idle(8);

      // Byte written during training waits for RUN
      do_reset();
      step(4'b0100, 32'h0011_0000, 1'b1);
      idle(6);

      // All four lanes on one edge with lane 0 first in line
      do_reset();
      idle(5);
      step(4'b1111, 32'hA3A2_A1A0, 1'b1);
      idle(6);

      // Lanes 1 and 3 hold two bytes each; lane 0 joins mid-sequence
      step(4'b1010, 32'h3100_1100, 1'b0);
      step(4'b1010, 32'h3200_1200, 1'b0);
      step(4'b0000, 32'h0,         1'b1);
      step(4'b0001, 32'h0000_0001, 1'b1);
      idle(6);

      // Overflow of lane 0 while the serializer stalls
      for (int i = 0; i < 5; i++) step(4'b0001, 32'(8'h50 + i), 1'b0);
      idle(7);

      // Reset with bytes still queued
      for (int i = 0; i < 3; i++) step(4'b0010, 32'(8'h60 + i) << 8, 1'b0);
      do_reset();
      idle(8);

      // Random traffic, random back-pressure, occasional reset
      for (int n = 0; n < 1500; n++) begin
         logic [3:0] v;
         for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 399) == 0) do_reset();
         step(v, $urandom, ($urandom_range(0, 3) != 0));
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
